// File: rtl/arm_seq_pkg.sv
// Shared types and default sizes for the ARM memory sequencer.
//   seq_state_t  : sequencer state encoding
//   DEF_*        : default parameter values used by the top level
//   is_bus_state : true for states that own the bus request
package arm_seq_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_MAX_WAIT = 16;
  localparam int unsigned DEF_CNT_W    = 32;

  typedef enum logic [2:0] {
    RST_WAIT = 3'd0,
    FETCH    = 3'd1,
    EXEC     = 3'd2,
    DATA     = 3'd3,
    COMMIT   = 3'd4,
    FAULT    = 3'd5
  } seq_state_t;

  function automatic logic is_bus_state(input seq_state_t s);
    return (s == FETCH) || (s == DATA);
  endfunction

endpackage

// File: rtl/arm_seq_timeout.sv
// Bus wait-state watchdog for the ARM memory sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : hold counter at zero (no request outstanding)
//   busy_i     : request outstanding and not answered this cycle
//   expired_o  : this unanswered cycle is the MAX_WAIT-th one
// MAX_WAIT = 0 disables the watchdog entirely.
module arm_seq_timeout #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic busy_i,
  output logic expired_o
);

  generate
    if (MAX_WAIT == 0) begin : g_off
      logic unused_s;
      assign unused_s  = ^{clk, rst_n, clear_i, busy_i};
      assign expired_o = 1'b0;
    end else begin : g_on
      localparam int unsigned   CW   = $clog2(MAX_WAIT + 1);
      localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

      logic [CW-1:0] cnt_q;

      // Count unanswered request cycles; zero whenever no request is open.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (clear_i) begin
          cnt_q <= '0;
        end else if (busy_i) begin
          cnt_q <= cnt_q + CW'(1);
        end else begin
          cnt_q <= cnt_q;
        end
      end

      // Flag on the cycle whose increment would reach MAX_WAIT, so the FSM
      // leaves the bus state after exactly MAX_WAIT request cycles.
      assign expired_o = busy_i && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/arm_mem_sequencer.sv
// Sequences an ARM core's split fetch/data interface onto one unified
// req/ready memory bus, stalling the core while the bus is busy.
//   clk, reset         : clock, asynchronous active-low reset
//   core_pc            : fetch address
//   core_instr         : latched instruction
//   core_memread/write : current instruction is a load / store
//   core_addr/wdata    : data address and store data
//   core_rdata         : latched load data
//   core_stall         : core holds state while high
//   bus_req/we/addr/wdata, bus_ready/rdata/err : unified memory bus
//   fault              : sticky trap (bus error or timeout)
//   instr_count        : retired-instruction counter (wraps)
module arm_mem_sequencer
  import arm_seq_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_pc,
  output logic [DATA_W-1:0] core_instr,
  input  logic              core_memread,
  input  logic              core_memwrite,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err,
  output logic              fault,
  output logic [CNT_W-1:0]  instr_count
);

  seq_state_t        state_q;
  logic              bus_req_q;
  logic              fault_q;
  logic [DATA_W-1:0] core_instr_q;
  logic [DATA_W-1:0] core_rdata_q;
  logic [CNT_W-1:0]  instr_count_q;

  logic              mem_op_s;
  logic              is_load_s;
  logic              busy_s;
  logic              expired_s;
  logic              stall_s;
  logic              bus_we_s;
  logic [ADDR_W-1:0] bus_addr_s;
  logic [DATA_W-1:0] bus_wdata_s;

  // A store wins when both memory flags are set.
  assign mem_op_s  = core_memread | core_memwrite;
  assign is_load_s = core_memread & ~core_memwrite;
  assign busy_s    = bus_req_q & ~bus_ready;

  arm_seq_timeout #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (reset),
    .clear_i   (~bus_req_q),
    .busy_i    (busy_s),
    .expired_o (expired_s)
  );

  // Sequencer FSM; bus_req is registered from the next state so it never
  // depends combinationally on bus_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RST_WAIT;
      bus_req_q     <= 1'b0;
      fault_q       <= 1'b0;
      core_instr_q  <= '0;
      core_rdata_q  <= '0;
      instr_count_q <= '0;
    end else begin
      case (state_q)
        RST_WAIT: begin
          state_q   <= FETCH;
          bus_req_q <= 1'b1;
        end
        FETCH: begin
          if (bus_ready && bus_err) begin
            state_q   <= FAULT;
            bus_req_q <= 1'b0;
            fault_q   <= 1'b1;
          end else if (bus_ready) begin
            core_instr_q <= bus_rdata;
            state_q      <= EXEC;
            bus_req_q    <= 1'b0;
          end else if (expired_s) begin
            state_q   <= FAULT;
            bus_req_q <= 1'b0;
            fault_q   <= 1'b1;
          end else begin
            state_q <= FETCH;
          end
        end
        EXEC: begin
          if (mem_op_s) begin
            state_q   <= DATA;
            bus_req_q <= 1'b1;
          end else begin
            instr_count_q <= instr_count_q + CNT_W'(1);
            state_q       <= FETCH;
            bus_req_q     <= 1'b1;
          end
        end
        DATA: begin
          if (bus_ready && bus_err) begin
            state_q   <= FAULT;
            bus_req_q <= 1'b0;
            fault_q   <= 1'b1;
          end else if (bus_ready) begin
            if (is_load_s) begin
              core_rdata_q <= bus_rdata;
            end else begin
              core_rdata_q <= core_rdata_q;
            end
            state_q   <= COMMIT;
            bus_req_q <= 1'b0;
          end else if (expired_s) begin
            state_q   <= FAULT;
            bus_req_q <= 1'b0;
            fault_q   <= 1'b1;
          end else begin
            state_q <= DATA;
          end
        end
        COMMIT: begin
          instr_count_q <= instr_count_q + CNT_W'(1);
          state_q       <= FETCH;
          bus_req_q     <= 1'b1;
        end
        FAULT: begin
          state_q   <= FAULT;
          bus_req_q <= 1'b0;
          fault_q   <= 1'b1;
        end
        default: begin
          state_q   <= FAULT;
          bus_req_q <= 1'b0;
          fault_q   <= 1'b1;
        end
      endcase
    end
  end

  // Bus payload and stall follow the current state; the core holds its
  // address/data inputs stable while stalled, so the payload is stable too.
  always_comb begin
    bus_addr_s  = '0;
    bus_we_s    = 1'b0;
    bus_wdata_s = '0;
    stall_s     = 1'b1;
    case (state_q)
      FETCH: begin
        bus_addr_s = core_pc;
      end
      EXEC: begin
        stall_s = mem_op_s;
      end
      DATA: begin
        bus_addr_s  = core_addr;
        bus_we_s    = core_memwrite;
        bus_wdata_s = core_wdata;
      end
      COMMIT: begin
        stall_s = 1'b0;
      end
      default: begin
        stall_s = 1'b1;
      end
    endcase
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_s;
  assign bus_addr    = bus_addr_s;
  assign bus_wdata   = bus_wdata_s;
  assign core_stall  = stall_s;
  assign core_instr  = core_instr_q;
  assign core_rdata  = core_rdata_q;
  assign fault       = fault_q;
  assign instr_count = instr_count_q;

  logic unused_s;
  assign unused_s = is_bus_state(state_q);

endmodule

// File: doc/arm_mem_sequencer.md
Name: arm_mem_sequencer

Overview:
- Parametrised successor to the single-cycle core top.
- Sits between the ARM core's split instruction/data interface (PC/Instr, ALUResult/WriteData/ReadData/MemWrite) and one unified memory bus with a req/ready handshake and variable wait states.
- Sequences fetch and data access over that single port, stalls the core while the bus is busy, counts retired instructions, and traps on bus error or timeout.

Parameters:
- ADDR_W, 32: bus and core address width.
- DATA_W, 32: instruction/data width.
- MAX_WAIT, 16: max cycles bus_req may stay unanswered before FAULT; 0 disables timeout.
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- core_pc  in  ADDR_W  fetch address from core.
- core_instr  out  DATA_W  latched instruction to core.
- core_memread  in  1  current instruction is a load.
- core_memwrite  in  1  current instruction is a store.
- core_addr  in  ADDR_W  data address (ALUResult).
- core_wdata  in  DATA_W  store data (WriteData).
- core_rdata  out  DATA_W  latched load data (ReadData).
- core_stall  out  1  core must hold PC/register state while high.
- bus_req  out  1  transfer request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  transfer address.
- bus_wdata  out  DATA_W  write data.
- bus_ready  in  1  transfer complete this cycle.
- bus_rdata  in  DATA_W  read data, valid with bus_ready.
- bus_err  in  1  transfer failed, qualified by bus_ready.
- fault  out  1  sticky trap indicator.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset low, async) forces the following, including mid-transfer:
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - core_stall=1, core_instr=0, core_rdata=0, fault=0, instr_count=0.
  - state=RST_WAIT, wait counter=0.
- States:
  - RST_WAIT: one cycle after reset release; then FETCH.
  - FETCH:
    - bus_req=1, bus_we=0, bus_addr=core_pc.
    - On bus_ready & !bus_err: core_instr<=bus_rdata, go EXEC.
  - EXEC: core decodes the latched instruction.
    - If core_memread|core_memwrite: go DATA, stall held.
    - Else: core_stall=0 for this cycle, instr_count++, go FETCH.
  - DATA:
    - bus_req=1, bus_addr=core_addr, bus_we=core_memwrite, bus_wdata=core_wdata.
    - On bus_ready & !bus_err: if read, core_rdata<=bus_rdata; go COMMIT.
  - COMMIT: core_stall=0 for one cycle, instr_count++, go FETCH.
  - FAULT: bus_req=0, core_stall=1, fault=1. Exit only via reset.
- Handshake:
  - Transfer completes on the cycle where bus_req & bus_ready are both high.
  - bus_addr/bus_we/bus_wdata stay stable while bus_req is high and not yet ready.
  - bus_ready with bus_req low is ignored.
  - bus_req is registered: driven from state, no combinational path from bus_ready.
- Latency with bus_ready tied high:
  - non-memory instruction: 2 cycles (FETCH, EXEC).
  - load/store: 4 cycles (FETCH, EXEC, DATA, COMMIT).
  - Each bus wait cycle adds one cycle.
- core_stall is low in exactly one cycle per retired instruction; it is high in every other state.
- Both core_memread and core_memwrite high: treated as a write.
- Timeout:
  - The wait counter clears on entry to FETCH/DATA and increments each cycle bus_req is high without bus_ready.
  - When the counter reaches MAX_WAIT (MAX_WAIT>0), go FAULT.
- bus_err with bus_ready: go FAULT; core_instr and core_rdata are not updated.
- instr_count wraps modulo 2^CNT_W and does not saturate.
- core_rdata holds its last value across fetches and non-load instructions.

Decomposition:
- Package arm_seq_pkg holds:
  - state enum seq_state_t {RST_WAIT, FETCH, EXEC, DATA, COMMIT, FAULT}.
  - localparam constants for default widths.
- One sub-module, arm_seq_timeout: the wait counter.
  - Inputs: clear, busy (req & !ready).
  - Output: expired.
  - Parameter: MAX_WAIT, with MAX_WAIT=0 tying expired to 0.

Test Plan:
- Zero-wait ALU stream: bus_ready=1, three non-memory instructions at PC 0,4,8 -> bus_addr 0,4,8 on fetch cycles; core_stall low every 2nd cycle; instr_count=3 after 6 cycles.
- Load with 3 wait states: instruction at PC 0x10 loads from 0x100, bus_rdata=0xDEADBEEF -> DATA bus_addr=0x100 held stable 4 cycles with bus_we=0; core_rdata=0xDEADBEEF in COMMIT; stall low once.
- Store: core_memwrite=1, addr 0x200, wdata 0x12345678, ready after 1 wait -> bus_we=1 with stable addr/data for 2 cycles; core_rdata unchanged.
- Timeout, MAX_WAIT=4: bus_ready never asserted in FETCH -> fault=1 and bus_req=0 after 4 req cycles; core_stall stays 1; state persists 20 further cycles.
- Bus error: bus_ready&bus_err during DATA load -> FAULT; core_rdata keeps its old value; instr_count not incremented.
- Reset mid-transfer: pull reset low during DATA wait -> bus_req drops asynchronously the same cycle; after release, one RST_WAIT cycle then a FETCH from current core_pc with fault=0 and instr_count=0.
